// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Load-use stall and taken-branch flush control for ID/EX/MEM.
//            Optional statistics counters enabled by macro HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_wb_dest,
    input  logic             mem_branch,
    input  logic             mem_zero,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [3:0] c_REM_INIT = 4'(LOAD_STALL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       w_hazard;
    logic       w_taken;

    // Register 0 is hard-wired, so a load targeting it can never create a dependency.
    assign w_hazard = id_valid & ex_MemRead & (ex_wb_dest != 5'd0) &
                      ((ex_wb_dest == id_rs) | (id_uses_rt & (ex_wb_dest == id_rt)));
    assign w_taken  = mem_branch & mem_zero;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        stalled     = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_taken) begin
            // A taken branch always wins and aborts any stall in progress.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
            rem_d       = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (w_hazard) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        stalled    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = STALL;
                            rem_d   = c_REM_INIT;
                        end
                    end
                end
                STALL: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stalled    = 1'b1;
                    rem_d      = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (w_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    // Output pattern order: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, stalled}
    localparam logic [5:0] c_RST   = 6'b001110;
    localparam logic [5:0] c_NORM  = 6'b110000;
    localparam logic [5:0] c_HAZ   = 6'b000101;
    localparam logic [5:0] c_TAKEN = 6'b111110;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rt, ex_MemRead, mem_branch, mem_zero;
    logic [4:0] id_rs, id_rt, ex_wb_dest;

    logic        u1_pc, u1_ifw, u1_iff, u1_idf, u1_exf, u1_st;
    logic [15:0] u1_scnt, u1_fcnt;
    logic        u3_pc, u3_ifw, u3_iff, u3_idf, u3_exf, u3_st;
    logic [3:0]  u3_scnt, u3_fcnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_MemRead(ex_MemRead), .ex_wb_dest(ex_wb_dest),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .pc_write(u1_pc),
        .ifid_write(u1_ifw), .ifid_flush(u1_iff), .idex_flush(u1_idf),
        .exmem_flush(u1_exf), .stalled(u1_st), .stall_cnt(u1_scnt), .flush_cnt(u1_fcnt)
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_MemRead(ex_MemRead), .ex_wb_dest(ex_wb_dest),
        .mem_branch(mem_branch), .mem_zero(mem_zero), .pc_write(u3_pc),
        .ifid_write(u3_ifw), .ifid_flush(u3_iff), .idex_flush(u3_idf),
        .exmem_flush(u3_exf), .stalled(u3_st), .stall_cnt(u3_scnt), .flush_cnt(u3_fcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat1();
        return 32'({u1_pc, u1_ifw, u1_iff, u1_idf, u1_exf, u1_st});
    endfunction

    function automatic logic [31:0] pat3();
        return 32'({u3_pc, u3_ifw, u3_iff, u3_idf, u3_exf, u3_st});
    endfunction

    // Advance one clock and let the combinational outputs settle on the new state.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_uses_rt = 1'b0; ex_MemRead = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; ex_wb_dest = 5'd0;
    endtask

    task automatic set_load_hazard(input logic [4:0] r);
        id_valid = 1'b1; ex_MemRead = 1'b1; ex_wb_dest = r; id_rs = r;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("reset_pattern_u1", pat1(), 32'(c_RST));
        check("reset_pattern_u3", pat3(), 32'(c_RST));
        step();
        check("reset_stall_cnt", 32'(u1_scnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("run_idle", pat1(), 32'(c_NORM));

        // Basic rs load-use hazard, single cycle stall
        set_load_hazard(5'd8);
        #1 check("haz_rs", pat1(), 32'(c_HAZ));
        step();
        ex_wb_dest = 5'd0;
        #1 check("haz_rs_release", pat1(), 32'(c_NORM));

        // Destination 0 never stalls; invalid ID never stalls
        id_rs = 5'd0; ex_MemRead = 1'b1; id_valid = 1'b1;
        #1 check("dest_zero", pat1(), 32'(c_NORM));
        id_valid = 1'b0; ex_wb_dest = 5'd8; id_rs = 5'd8;
        #1 check("id_invalid", pat1(), 32'(c_NORM));
        step();

        // rt match only counts when rt is read
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd9; ex_wb_dest = 5'd9; id_uses_rt = 1'b0;
        #1 check("rt_unused", pat1(), 32'(c_NORM));
        id_uses_rt = 1'b1;
        #1 check("rt_used", pat1(), 32'(c_HAZ));
        ex_MemRead = 1'b0;
        #1 check("rt_not_load", pat1(), 32'(c_NORM));
        ex_MemRead = 1'b1;
        step();

        // Taken branch beats hazard; not-taken branch flushes nothing
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1 check("taken_beats_haz", pat1(), 32'(c_TAKEN));
        mem_zero = 1'b0;
        #1 check("untaken_with_haz", pat1(), 32'(c_HAZ));
        ex_MemRead = 1'b0;
        #1 check("untaken_no_haz", pat1(), 32'(c_NORM));

        // Three-cycle stall on the LOAD_STALL_CYCLES=3 instance
        do_reset();
        set_load_hazard(5'd8);
        #1 check("s3_cyc1", pat3(), 32'(c_HAZ));
        step();
        idle_inputs();
        #1 check("s3_cyc2", pat3(), 32'(c_HAZ));
        step();
        check("s3_cyc3", pat3(), 32'(c_HAZ));
        step();
        check("s3_done", pat3(), 32'(c_NORM));

        // Taken branch in the second stall cycle aborts the stall
        set_load_hazard(5'd8);
        step();
        idle_inputs();
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1 check("s3_taken_abort", pat3(), 32'(c_TAKEN));
        step();
        idle_inputs();
        #1 check("s3_after_abort", pat3(), 32'(c_NORM));

        // Reset in the middle of a stall returns to RUN
        set_load_hazard(5'd8);
        step();
        idle_inputs();
        rst_n = 1'b0;
        #1 check("s3_mid_reset", pat3(), 32'(c_RST));
        step();
        rst_n = 1'b1;
        #1 check("s3_after_reset", pat3(), 32'(c_NORM));

        // Statistics: 5 stall cycles and 2 taken cycles on the single-cycle instance
        do_reset();
        set_load_hazard(5'd5);
        repeat (5) step();
        idle_inputs();
        mem_branch = 1'b1; mem_zero = 1'b1;
        repeat (2) step();
        idle_inputs();
        step();
`ifdef HAZARD_STATS_EN
        check("stats_stall5", 32'(u1_scnt), 32'd5);
        check("stats_flush2", 32'(u1_fcnt), 32'd2);
`else
        check("stats_stall_off", 32'(u1_scnt), 32'd0);
        check("stats_flush_off", 32'(u1_fcnt), 32'd0);
`endif

        // Saturation: 20 consecutive stall cycles on the 4-bit counter instance
        do_reset();
        set_load_hazard(5'd3);
        repeat (20) step();
        idle_inputs();
        step();
`ifdef HAZARD_STATS_EN
        check("sat_stall_w4", 32'(u3_scnt), 32'd15);
        check("stall20_w16", 32'(u1_scnt), 32'd20);
`else
        check("sat_stall_off", 32'(u3_scnt), 32'd0);
        check("stall20_off", 32'(u1_scnt), 32'd0);
`endif
        check("sat_flush_none", 32'(u3_fcnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
